program_counter: RTL and testbench

4-bit CPU program counter: a registered address pointer that resets to zero, increments by one, or loads a jump target. It sits in the CPU datapath and drives the instruction-memory address; the control unit sequences it with `pc_inc`/`pc_load`. An optional hardware return stack supports call/return.

---
 rtl/pc_pkg.sv | 9 +
 rtl/pc_stack.sv | 66 ++++++
 rtl/program_counter.sv | 89 ++++++++
 tb/tb_program_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and address type for the program counter
package pc_pkg;

    localparam int DEFAULT_PC_WIDTH    = 4;
    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef logic [DEFAULT_PC_WIDTH-1:0] pc_addr_t;

endpackage : pc_pkg

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - LIFO return-address register file with occupancy pointer
module pc_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_PC_WIDTH,
    parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH + 1);

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (ptr_q == PW'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;

    always_comb begin
        ptr_d = ptr_q;
        if (do_push) begin
            ptr_d = ptr_q + PW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entry contents need no reset; only the pointer defines what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (ptr_q == PW'(i))) begin
                mem_q[i] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == PW'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

endmodule : pc_stack

// File: rtl/program_counter.sv
// rtl/program_counter.sv - CPU program counter; return stack built only with PC_STACK_EN
module program_counter
    import pc_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH
`ifdef PC_STACK_EN
    ,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_inc,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_in,
`ifdef PC_STACK_EN
    input  logic                pc_call,
    input  logic                pc_ret,
    output logic                stack_full,
    output logic                stack_empty,
`endif
    output logic [PC_WIDTH-1:0] pc_out
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

`ifdef PC_STACK_EN
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] stack_top;

    pc_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + PC_WIDTH'(1)),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // A blocked call or return still wins priority, so the PC simply holds.
    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
        if (pc_load) begin
            pc_d = pc_in;
        end else if (pc_call) begin
            if (!stack_full) begin
                push = 1'b1;
                pc_d = pc_in;
            end
        end else if (pc_ret) begin
            if (!stack_empty) begin
                pop  = 1'b1;
                pc_d = stack_top;
            end
        end else if (pc_inc) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end
`else
    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = pc_in;
        end else if (pc_inc) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - scoreboard bench for program_counter
module tb_program_counter;

    logic       clk;
    logic       reset;
    logic       pc_inc;
    logic       pc_load;
    logic [3:0] pc_in;
    logic [3:0] pc_out;
`ifdef PC_STACK_EN
    logic       pc_call;
    logic       pc_ret;
    logic       stack_full;
    logic       stack_empty;
`endif

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic       empty;
        logic       full;
        bit         flags;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    program_counter dut (
        .clk         (clk),
        .reset       (reset),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
`ifdef PC_STACK_EN
        .pc_call     (pc_call),
        .pc_ret      (pc_ret),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
`endif
        .pc_out      (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input bit inc, input bit load, input logic [3:0] din,
                        input bit call, input bit ret, input logic [3:0] e_pc,
                        input bit e_empty, input bit e_full, input bit flags);
        exp_t e;
        @(negedge clk);
        pc_inc  = inc;
        pc_load = load;
        pc_in   = din;
`ifdef PC_STACK_EN
        pc_call = call;
        pc_ret  = ret;
`endif
        e.name  = nm;
        e.pc    = e_pc;
        e.empty = e_empty;
        e.full  = e_full;
        e.flags = flags;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        pc_inc  = 1'b0;
        pc_load = 1'b0;
`ifdef PC_STACK_EN
        pc_call = 1'b0;
        pc_ret  = 1'b0;
`endif
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, 32'(pc_out), 32'(e.pc));
`ifdef PC_STACK_EN
                if (e.flags) begin
                    check({e.name, "_empty"}, 32'(stack_empty), 32'(e.empty));
                    check({e.name, "_full"}, 32'(stack_full), 32'(e.full));
                end
`endif
            end
        end
    end

    initial begin
        reset   = 1'b1;
        pc_inc  = 1'b0;
        pc_load = 1'b1;
        pc_in   = 4'd9;
`ifdef PC_STACK_EN
        pc_call = 1'b0;
        pc_ret  = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_async", 32'(pc_out), 32'd0);
`ifdef PC_STACK_EN
        check("reset_async_empty", 32'(stack_empty), 32'd1);
        check("reset_async_full", 32'(stack_full), 32'd0);
`endif
        @(posedge clk);
        #1;
        check("reset_hold", 32'(pc_out), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        pc_load = 1'b0;
        pc_in   = 4'd0;

        //    name         inc load in  call ret  pc    emp full flags
        step("idle0",      0, 0, 4'd0, 0, 0, 4'd0,  1, 0, 1);
        step("idle1",      0, 0, 4'd0, 0, 0, 4'd0,  1, 0, 1);
        step("inc1",       1, 0, 4'd0, 0, 0, 4'd1,  1, 0, 0);
        step("inc2",       1, 0, 4'd0, 0, 0, 4'd2,  1, 0, 0);
        step("inc3",       1, 0, 4'd0, 0, 0, 4'd3,  1, 0, 0);
        step("inc4",       1, 0, 4'd0, 0, 0, 4'd4,  1, 0, 0);
        step("inc5",       1, 0, 4'd0, 0, 0, 4'd5,  1, 0, 0);
        step("load9",      0, 1, 4'd9, 0, 0, 4'd9,  1, 0, 0);
        step("inc10",      1, 0, 4'd0, 0, 0, 4'd10, 1, 0, 0);
        step("inc11",      1, 0, 4'd0, 0, 0, 4'd11, 1, 0, 0);
        step("inc12",      1, 0, 4'd0, 0, 0, 4'd12, 1, 0, 0);
        step("hold_a",     0, 0, 4'd5, 0, 0, 4'd12, 1, 0, 0);
        step("hold_b",     0, 0, 4'd5, 0, 0, 4'd12, 1, 0, 0);
        step("load14",     0, 1, 4'd14,0, 0, 4'd14, 1, 0, 0);
        step("inc15",      1, 0, 4'd0, 0, 0, 4'd15, 1, 0, 0);
        step("wrap0",      1, 0, 4'd0, 0, 0, 4'd0,  1, 0, 0);
        step("wrap1",      1, 0, 4'd0, 0, 0, 4'd1,  1, 0, 0);
        step("load_over_inc", 1, 1, 4'd3, 0, 0, 4'd3, 1, 0, 0);
`ifdef PC_STACK_EN
        step("load2",      0, 1, 4'd2, 0, 0, 4'd2,  1, 0, 1);
        step("call8",      0, 0, 4'd8, 1, 0, 4'd8,  0, 0, 1);
        step("inc_in_sub", 1, 0, 4'd0, 0, 0, 4'd9,  0, 0, 1);
        step("ret3",       0, 0, 4'd0, 0, 1, 4'd3,  1, 0, 1);
        step("ret_empty",  0, 0, 4'd0, 0, 1, 4'd3,  1, 0, 1);
        step("load_over_call", 0, 1, 4'd6, 1, 0, 4'd6, 1, 0, 1);
        step("load3",      0, 1, 4'd3, 0, 0, 4'd3,  1, 0, 1);
        step("call_a",     0, 0, 4'd5, 1, 0, 4'd5,  0, 0, 1);
        step("call_b",     0, 0, 4'd6, 1, 0, 4'd6,  0, 0, 1);
        step("call_c",     0, 0, 4'd7, 1, 0, 4'd7,  0, 0, 1);
        step("call_d",     0, 0, 4'd10,1, 0, 4'd10, 0, 1, 1);
        step("call_full",  0, 0, 4'd12,1, 0, 4'd10, 0, 1, 1);
        step("ret_d",      0, 0, 4'd0, 0, 1, 4'd8,  0, 0, 1);
        step("ret_c",      0, 0, 4'd0, 0, 1, 4'd7,  0, 0, 1);
        step("call_again", 0, 0, 4'd1, 1, 0, 4'd1,  0, 0, 1);
`endif
        drain();

`ifdef PC_STACK_EN
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_mid_pc", 32'(pc_out), 32'd0);
        check("reset_mid_empty", 32'(stack_empty), 32'd1);
        check("reset_mid_full", 32'(stack_full), 32'd0);
        @(negedge clk);
        reset = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_program_counter
